// File: rtl/rv32i_exec_ctrl.sv
// Decode/execute slice of the single-cycle RV32I core: control decoder, ALU with
// operand muxes, branch comparator, and a retired-instruction counter.
module rv32i_exec_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            rst,
  input  logic [XLEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [XLEN-1:0] i_imm,
  output logic [2:0]      o_imm_sel,
  output logic [3:0]      o_alu_op,
  output logic            o_opa_sel,
  output logic [1:0]      o_opb_sel,
  output logic            o_alu_src_b_is_imm,
  output logic [XLEN-1:0] o_alu_y,
  output logic            o_alu_zero,
  output logic            o_reg_we,
  output logic            o_mem_we,
  output logic            o_mem_re,
  output logic [1:0]      o_wb_sel,
  output logic            o_br_un,
  output logic            o_br_equal,
  output logic            o_br_less,
  output logic            o_pc_src_branch,
  output logic            o_pc_src_jal,
  output logic            o_pc_src_jalr,
  output logic            o_insn_vld,
  output logic [XLEN-1:0] o_insn_cnt
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       is_branch;
  logic       unused_bits;

  assign opcode      = i_instr[6:0];
  assign funct3      = i_instr[14:12];
  assign funct7_b5   = i_instr[30];
  assign unused_bits = ^{i_instr[31], i_instr[29:15], i_instr[11:7]};

  // alt selects SUB for funct3 000 and SRA for funct3 101
  function automatic logic [3:0] f3_to_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  f3_to_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  f3_to_op = ALU_SLL;
      3'b010:  f3_to_op = ALU_SLT;
      3'b011:  f3_to_op = ALU_SLTU;
      3'b100:  f3_to_op = ALU_XOR;
      3'b101:  f3_to_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  f3_to_op = ALU_OR;
      default: f3_to_op = ALU_AND;
    endcase
  endfunction

  always_comb begin
    o_imm_sel    = IMM_I;
    o_alu_op     = ALU_ADD;
    o_opa_sel    = 1'b0;
    o_opb_sel    = 2'b00;
    o_reg_we     = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_re     = 1'b0;
    o_wb_sel     = 2'b00;
    o_br_un      = 1'b0;
    o_pc_src_jal = 1'b0;
    o_pc_src_jalr = 1'b0;
    o_insn_vld   = 1'b0;
    is_branch    = 1'b0;
    case (opcode)
      OPC_OP: begin
        o_insn_vld = 1'b1;
        o_alu_op   = f3_to_op(funct3, funct7_b5);
        o_reg_we   = 1'b1;
      end
      OPC_OP_IMM: begin
        o_insn_vld = 1'b1;
        o_alu_op   = f3_to_op(funct3, (funct3 == 3'b101) && funct7_b5);
        o_opb_sel  = 2'b01;
        o_reg_we   = 1'b1;
      end
      OPC_LOAD: begin
        o_insn_vld = 1'b1;
        o_opb_sel  = 2'b01;
        o_mem_re   = 1'b1;
        o_reg_we   = 1'b1;
        o_wb_sel   = 2'b01;
      end
      OPC_STORE: begin
        o_insn_vld = 1'b1;
        o_imm_sel  = IMM_S;
        o_opb_sel  = 2'b01;
        o_mem_we   = 1'b1;
      end
      OPC_BRANCH: begin
        if (funct3[2:1] != 2'b01) begin
          o_insn_vld = 1'b1;
          is_branch  = 1'b1;
          o_imm_sel  = IMM_B;
          o_opa_sel  = 1'b1;
          o_opb_sel  = 2'b01;
          o_br_un    = funct3[1];
        end
      end
      OPC_JAL: begin
        o_insn_vld   = 1'b1;
        o_imm_sel    = IMM_J;
        o_opa_sel    = 1'b1;
        o_opb_sel    = 2'b01;
        o_reg_we     = 1'b1;
        o_wb_sel     = 2'b10;
        o_pc_src_jal = 1'b1;
      end
      OPC_JALR: begin
        o_insn_vld    = 1'b1;
        o_opb_sel     = 2'b01;
        o_reg_we      = 1'b1;
        o_wb_sel      = 2'b10;
        o_pc_src_jalr = 1'b1;
      end
      OPC_LUI: begin
        o_insn_vld = 1'b1;
        o_imm_sel  = IMM_U;
        o_alu_op   = ALU_PASSB;
        o_opb_sel  = 2'b01;
        o_reg_we   = 1'b1;
      end
      OPC_AUIPC: begin
        o_insn_vld = 1'b1;
        o_imm_sel  = IMM_U;
        o_opa_sel  = 1'b1;
        o_opb_sel  = 2'b01;
        o_reg_we   = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_alu_src_b_is_imm = (o_opb_sel == 2'b01);

  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  logic [4:0]      shamt;

  assign opa   = o_opa_sel ? i_pc : i_rs1_data;
  assign shamt = opb[4:0];

  always_comb begin
    case (o_opb_sel)
      2'b00:   opb = i_rs2_data;
      2'b01:   opb = i_imm;
      2'b10:   opb = XLEN'(4);
      default: opb = '0;
    endcase
  end

  always_comb begin
    case (o_alu_op)
      ALU_ADD:   o_alu_y = opa + opb;
      ALU_SUB:   o_alu_y = opa - opb;
      ALU_SLL:   o_alu_y = opa << shamt;
      ALU_SLT:   o_alu_y = {{(XLEN-1){1'b0}}, $signed(opa) < $signed(opb)};
      ALU_SLTU:  o_alu_y = {{(XLEN-1){1'b0}}, opa < opb};
      ALU_XOR:   o_alu_y = opa ^ opb;
      ALU_SRL:   o_alu_y = opa >> shamt;
      ALU_SRA:   o_alu_y = $signed(opa) >>> shamt;
      ALU_OR:    o_alu_y = opa | opb;
      ALU_AND:   o_alu_y = opa & opb;
      ALU_PASSB: o_alu_y = opb;
      default:   o_alu_y = '0;
    endcase
  end

  assign o_alu_zero = (o_alu_y == '0);

  // Comparator always runs on the raw regfile operands, independent of the ALU muxes.
  assign o_br_equal = (i_rs1_data == i_rs2_data);
  assign o_br_less  = o_br_un ? (i_rs1_data < i_rs2_data)
                              : ($signed(i_rs1_data) < $signed(i_rs2_data));

  always_comb begin
    o_pc_src_branch = 1'b0;
    if (is_branch) begin
      case (funct3)
        3'b000:         o_pc_src_branch = o_br_equal;
        3'b001:         o_pc_src_branch = !o_br_equal;
        3'b100, 3'b110: o_pc_src_branch = o_br_less;
        3'b101, 3'b111: o_pc_src_branch = !o_br_less;
        default:        o_pc_src_branch = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!rst) begin
      o_insn_cnt <= '0;
    end else if (o_insn_vld) begin
      o_insn_cnt <= o_insn_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rv32i_exec_ctrl.sv
// Scoreboard bench for rv32i_exec_ctrl: the driver pushes model expectations per
// cycle, a negedge monitor pops and compares against the DUT outputs.
module tb_rv32i_exec_ctrl;

  logic        i_clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] i_instr = '0, i_pc = '0, i_rs1_data = '0, i_rs2_data = '0, i_imm = '0;
  logic [2:0]  o_imm_sel;
  logic [3:0]  o_alu_op;
  logic        o_opa_sel;
  logic [1:0]  o_opb_sel;
  logic        o_alu_src_b_is_imm;
  logic [31:0] o_alu_y;
  logic        o_alu_zero, o_reg_we, o_mem_we, o_mem_re;
  logic [1:0]  o_wb_sel;
  logic        o_br_un, o_br_equal, o_br_less;
  logic        o_pc_src_branch, o_pc_src_jal, o_pc_src_jalr, o_insn_vld;
  logic [31:0] o_insn_cnt;

  always #5 i_clk = ~i_clk;

  rv32i_exec_ctrl #(.XLEN(32)) dut (
    .i_clk(i_clk), .rst(rst), .i_instr(i_instr), .i_pc(i_pc),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm(i_imm),
    .o_imm_sel(o_imm_sel), .o_alu_op(o_alu_op), .o_opa_sel(o_opa_sel),
    .o_opb_sel(o_opb_sel), .o_alu_src_b_is_imm(o_alu_src_b_is_imm),
    .o_alu_y(o_alu_y), .o_alu_zero(o_alu_zero), .o_reg_we(o_reg_we),
    .o_mem_we(o_mem_we), .o_mem_re(o_mem_re), .o_wb_sel(o_wb_sel),
    .o_br_un(o_br_un), .o_br_equal(o_br_equal), .o_br_less(o_br_less),
    .o_pc_src_branch(o_pc_src_branch), .o_pc_src_jal(o_pc_src_jal),
    .o_pc_src_jalr(o_pc_src_jalr), .o_insn_vld(o_insn_vld), .o_insn_cnt(o_insn_cnt)
  );

  typedef struct packed {
    logic [2:0]  imm_sel;
    logic [3:0]  alu_op;
    logic        opa;
    logic [1:0]  opb;
    logic [31:0] y;
    logic        reg_we, mem_we, mem_re;
    logic [1:0]  wb;
    logic        br_un, br_eq, br_less, taken, jal, jalr, vld;
    logic        skip_cmp;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    exp_t        e;
    logic        chk_cnt;
    logic [31:0] cnt;
    logic        lit_y_en;
    logic [31:0] lit_y;
    logic        lit_cnt_en;
    logic [31:0] lit_cnt;
  } txn_t;

  txn_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  int          txn_no = 0;
  logic [31:0] model_cnt = '0;
  logic        cnt_known = 1'b0;
  logic        stim_done = 1'b0;

  // Reference semantics of one instruction, written from the ISA rules.
  function automatic exp_t model(input logic [31:0] ins, pc, a, b, imm);
    exp_t e;
    logic [2:0]  f3 = ins[14:12];
    logic        alt = ins[30];
    logic        is_imm;
    logic [31:0] bv;
    e = '0;
    e.y = a + b;
    case (ins[6:0])
      7'b0110011, 7'b0010011: begin
        is_imm = (ins[6:0] == 7'b0010011);
        bv = is_imm ? imm : b;
        e.vld = 1; e.reg_we = 1; e.opb = is_imm ? 2'b01 : 2'b00;
        case (f3)
          3'd0: if (alt && !is_imm) begin e.alu_op = 1; e.y = a - bv; end
                else begin e.alu_op = 0; e.y = a + bv; end
          3'd1: begin e.alu_op = 2; e.y = a << bv[4:0]; end
          3'd2: begin e.alu_op = 3; e.y = ($signed(a) < $signed(bv)) ? 1 : 0; end
          3'd3: begin e.alu_op = 4; e.y = (a < bv) ? 1 : 0; end
          3'd4: begin e.alu_op = 5; e.y = a ^ bv; end
          3'd5: if (alt) begin e.alu_op = 7; e.y = 32'($signed(a) >>> bv[4:0]); end
                else begin e.alu_op = 6; e.y = a >> bv[4:0]; end
          3'd6: begin e.alu_op = 8; e.y = a | bv; end
          default: begin e.alu_op = 9; e.y = a & bv; end
        endcase
      end
      7'b0000011: begin e.vld = 1; e.opb = 1; e.mem_re = 1; e.reg_we = 1; e.wb = 1; e.y = a + imm; end
      7'b0100011: begin e.vld = 1; e.imm_sel = 1; e.opb = 1; e.mem_we = 1; e.y = a + imm; end
      7'b1100011: begin
        if (f3 == 3'b010 || f3 == 3'b011) begin
          e.skip_cmp = 1;
        end else begin
          e.vld = 1; e.imm_sel = 2; e.opa = 1; e.opb = 1; e.y = pc + imm; e.br_un = f3[1];
        end
      end
      7'b1101111: begin e.vld = 1; e.imm_sel = 4; e.opa = 1; e.opb = 1; e.reg_we = 1; e.wb = 2; e.jal = 1; e.y = pc + imm; end
      7'b1100111: begin e.vld = 1; e.opb = 1; e.reg_we = 1; e.wb = 2; e.jalr = 1; e.y = a + imm; end
      7'b0110111: begin e.vld = 1; e.imm_sel = 3; e.alu_op = 10; e.opb = 1; e.reg_we = 1; e.y = imm; end
      7'b0010111: begin e.vld = 1; e.imm_sel = 3; e.opa = 1; e.opb = 1; e.reg_we = 1; e.y = pc + imm; end
      default: ;
    endcase
    e.br_eq   = (a == b);
    e.br_less = e.br_un ? (a < b) : ($signed(a) < $signed(b));
    if (e.vld && ins[6:0] == 7'b1100011) begin
      case (f3)
        3'd0: e.taken = e.br_eq;
        3'd1: e.taken = !e.br_eq;
        3'd4, 3'd6: e.taken = e.br_less;
        default: e.taken = !e.br_less;
      endcase
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s (txn %0d instr=%08h): got %08h, expected %08h", name, txn_no, i_instr, act, exp_v);
    end
  endtask

  task automatic drive(input logic [31:0] ins, pc, a, b, imm, input logic r,
                       input logic ly_en, input logic [31:0] ly,
                       input logic lc_en, input logic [31:0] lc);
    txn_t t;
    @(posedge i_clk);
    #1;
    i_instr = ins; i_pc = pc; i_rs1_data = a; i_rs2_data = b; i_imm = imm; rst = r;
    t.instr = ins;
    t.e = model(ins, pc, a, b, imm);
    t.chk_cnt = cnt_known;
    t.cnt = model_cnt;
    t.lit_y_en = ly_en; t.lit_y = ly;
    t.lit_cnt_en = lc_en; t.lit_cnt = lc;
    sb_q.push_back(t);
    if (!r) begin
      model_cnt = '0;
      cnt_known = 1'b1;
    end else if (t.e.vld) begin
      model_cnt = model_cnt + 1;
    end
  endtask

  task automatic op(input logic [31:0] ins, pc, a, b, imm, input logic [31:0] y);
    drive(ins, pc, a, b, imm, 1'b1, 1'b1, y, 1'b0, 32'd0);
  endtask

  initial begin : monitor
    txn_t t;
    forever begin
      @(negedge i_clk);
      if (sb_q.size() != 0) begin
        t = sb_q.pop_front();
        txn_no++;
        chk("insn_vld", 32'(o_insn_vld), 32'(t.e.vld));
        chk("imm_sel", 32'(o_imm_sel), 32'(t.e.imm_sel));
        chk("alu_op", 32'(o_alu_op), 32'(t.e.alu_op));
        chk("opa_sel", 32'(o_opa_sel), 32'(t.e.opa));
        chk("opb_sel", 32'(o_opb_sel), 32'(t.e.opb));
        chk("src_b_is_imm", 32'(o_alu_src_b_is_imm), 32'(t.e.opb == 2'b01));
        chk("alu_y", o_alu_y, t.e.y);
        chk("alu_zero", 32'(o_alu_zero), 32'(t.e.y == 0));
        chk("reg_we", 32'(o_reg_we), 32'(t.e.reg_we));
        chk("mem_we", 32'(o_mem_we), 32'(t.e.mem_we));
        chk("mem_re", 32'(o_mem_re), 32'(t.e.mem_re));
        chk("wb_sel", 32'(o_wb_sel), 32'(t.e.wb));
        chk("br_equal", 32'(o_br_equal), 32'(t.e.br_eq));
        if (!t.e.skip_cmp) begin
          chk("br_un", 32'(o_br_un), 32'(t.e.br_un));
          chk("br_less", 32'(o_br_less), 32'(t.e.br_less));
        end
        chk("pc_src_branch", 32'(o_pc_src_branch), 32'(t.e.taken));
        chk("pc_src_jal", 32'(o_pc_src_jal), 32'(t.e.jal));
        chk("pc_src_jalr", 32'(o_pc_src_jalr), 32'(t.e.jalr));
        if (t.chk_cnt) chk("insn_cnt", o_insn_cnt, t.cnt);
        if (t.lit_y_en) chk("alu_y_const", o_alu_y, t.lit_y);
        if (t.lit_cnt_en) chk("insn_cnt_const", o_insn_cnt, t.lit_cnt);
        $display("txn %0d instr=%08h y=%08h vld=%0d cnt=%0d errors=%0d",
                 txn_no, t.instr, o_alu_y, o_insn_vld, o_insn_cnt, errors);
      end
    end
  end

  localparam logic [6:0] OPCODES [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                         7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

  initial begin : stimulus
    logic [31:0] ins, a, b;
    logic        r;
    // counter reset held for two cycles; second cycle must read 0
    drive(32'h002081B3, 0, 1, 2, 0, 1'b0, 1'b0, 0, 1'b0, 0);
    drive(32'h002081B3, 0, 1, 2, 0, 1'b0, 1'b0, 0, 1'b1, 32'd0);
    op(32'h002081B3, 0, 32'h7FFFFFFF, 32'h1, 0, 32'h80000000);
    op(32'h402081B3, 0, 32'd5, 32'd5, 0, 32'h0);
    op(32'h4020D1B3, 0, 32'h80000000, 32'd4, 0, 32'hF8000000);
    drive(32'h00000000, 0, 32'h11, 32'h22, 32'h33, 1'b1, 1'b1, 32'h33, 1'b1, 32'd3);
    op(32'h0020D1B3, 0, 32'h80000000, 32'd4, 0, 32'h08000000);
    op(32'h0020A1B3, 0, 32'hFFFFFFFF, 32'd1, 0, 32'd1);
    op(32'h0020B1B3, 0, 32'hFFFFFFFF, 32'd1, 0, 32'd0);
    op(32'h0020C063, 32'h200, 32'hFFFFFFFF, 32'd1, 32'h40, 32'h240);
    op(32'h0020E063, 32'h200, 32'hFFFFFFFF, 32'd1, 32'h40, 32'h240);
    op(32'h00208063, 32'h300, 32'd7, 32'd7, 32'h10, 32'h310);
    op(32'h0000006F, 32'h100, 32'hDEAD, 32'hBEEF, 32'h20, 32'h120);
    op(32'h000001B7, 32'h40, 32'hDEAD, 32'hBEEF, 32'h12345000, 32'h12345000);
    op(32'h00000197, 32'h10, 32'hDEAD, 32'hBEEF, 32'h12345000, 32'h12345010);
    drive(32'h002081B3, 0, 1, 2, 0, 1'b0, 1'b0, 0, 1'b0, 0);
    drive(32'h002081B3, 0, 1, 2, 0, 1'b1, 1'b0, 0, 1'b1, 32'd0);
    for (int i = 0; i < 400; i++) begin
      ins = $urandom;
      if ($urandom_range(0, 7) != 0) ins[6:0] = OPCODES[$urandom_range(0, 8)];
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) b = {27'd0, b[4:0]};
      r = ($urandom_range(0, 31) != 0);
      drive(ins, $urandom, a, b, $urandom, r, 1'b0, 0, 1'b0, 0);
    end
    repeat (3) @(posedge i_clk);
    stim_done = 1'b1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32i_exec_ctrl.md
Name: rv32i_exec_ctrl

Overview:
- Combined decode/execute slice of the single-cycle RV32I core.
- Three parts:
  - instruction decoder (control);
  - 32-bit ALU with its operand muxes;
  - branch comparator, which resolves branch-taken.
- Sits between fetch/regfile/immgen and LSU/writeback/PC-next logic.
- Single state element: a retired-instruction counter.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- i_clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- i_instr  in  32  fetched instruction.
- i_pc  in  32  PC of i_instr.
- i_rs1_data  in  32  regfile port 1.
- i_rs2_data  in  32  regfile port 2.
- i_imm  in  32  sign-extended immediate from immgen.
- o_imm_sel  out  3  immediate format: 0 I, 1 S, 2 B, 3 U, 4 J.
- o_alu_op  out  4  ALU operation code (see Behaviour).
- o_opa_sel  out  1  operand A select: 0 = rs1, 1 = pc.
- o_opb_sel  out  2  operand B select: 00 rs2, 01 imm, 10 constant 4.
- o_alu_src_b_is_imm  out  1  1 when o_opb_sel == 01.
- o_alu_y  out  32  ALU result.
- o_alu_zero  out  1  o_alu_y == 0.
- o_reg_we  out  1  register write enable.
- o_mem_we  out  1  store.
- o_mem_re  out  1  load.
- o_wb_sel  out  2  writeback source: 00 ALU, 01 load data, 10 pc+4.
- o_br_un  out  1  unsigned compare (funct3 BLTU/BGEU).
- o_br_equal  out  1  rs1 == rs2.
- o_br_less  out  1  rs1 < rs2 (signed, or unsigned when o_br_un = 1).
- o_pc_src_branch  out  1  conditional branch taken.
- o_pc_src_jal  out  1  JAL.
- o_pc_src_jalr  out  1  JALR.
- o_insn_vld  out  1  i_instr decodes to a supported RV32I opcode.
- o_insn_cnt  out  32  count of cycles with o_insn_vld = 1.

Behaviour:
- Everything except o_insn_cnt is purely combinational: zero-latency, no handshake.
- ALU ops (o_alu_op):
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU;
  - 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB (y = B);
  - 11–15 give y = 0.
  - Shift amount = B[4:0]. All arithmetic wraps modulo 2^32.
- Operand muxes:
  - A = o_opa_sel ? i_pc : i_rs1_data.
  - B = rs2, imm, or 4 per o_opb_sel; o_opb_sel = 11 gives B = 0.
- Decode by opcode[6:0]:
  - OP (0110011):
    - ALU op from funct3/funct7[5]: 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
    - opa rs1, opb rs2, reg_we 1, wb ALU.
  - OP-IMM (0010011):
    - Same funct3 map; funct7[5] is used only for 101 (SRAI). funct3 000 is always ADD.
    - opb imm, imm_sel I, reg_we 1.
  - LOAD (0000011): ADD, opb imm, imm_sel I, mem_re 1, reg_we 1, wb load.
  - STORE (0100011): ADD, opb imm, imm_sel S, mem_we 1, reg_we 0.
  - BRANCH (1100011):
    - imm_sel B, opa pc, opb imm, ADD (target), reg_we 0.
    - o_br_un = funct3[1].
    - Taken by funct3: BEQ eq, BNE !eq, BLT/BLTU less, BGE/BGEU !less.
    - funct3 010/011 are invalid.
  - JAL (1101111): imm_sel J, opa pc, opb imm, ADD, reg_we 1, wb pc+4, o_pc_src_jal 1.
  - JALR (1100111): imm_sel I, opa rs1, opb imm, ADD, reg_we 1, wb pc+4, o_pc_src_jalr 1.
  - LUI (0110111): imm_sel U, PASSB, opb imm, reg_we 1, wb ALU.
  - AUIPC (0010111): imm_sel U, opa pc, opb imm, ADD, reg_we 1, wb ALU.
- Unsupported opcode, or branch with funct3 010/011:
  - o_insn_vld 0;
  - reg_we, mem_we, mem_re and all pc_src outputs 0;
  - alu_op ADD, opa 0, opb 00, wb 00, imm_sel 0.
- Comparator runs on every cycle regardless of opcode. o_br_un is 0 for non-branch instructions.
- Counter:
  - On rising i_clk, if rst = 0 then o_insn_cnt <= 0.
  - Otherwise, if o_insn_vld = 1, o_insn_cnt increments, wrapping from 0xFFFFFFFF to 0.
- Reset does not affect the combinational outputs. Reset asserted in mid-run clears the counter on that edge only.

Test Plan:
- ADD x3, x1, x2 (0x002081B3), rs1 = 0x7FFFFFFF, rs2 = 1:
  - y = 0x80000000, reg_we 1, wb 00, alu_op 0, insn_vld 1.
  - Same operands with SUB (0x402081B3) and rs1 = rs2 = 5: y = 0, zero 1.
- SRA with rs1 = 0x80000000, B = 4: y = 0xF8000000. Same operands with SRL: y = 0x08000000.
- SLT/SLTU with rs1 = 0xFFFFFFFF, rs2 = 1: SLT y = 1, SLTU y = 0.
- BLT with rs1 = -1, rs2 = 1:
  - br_less 1, br_un 0, pc_src_branch 1.
  - Same operands with BLTU: br_un 1, br_less 0, pc_src_branch 0.
  - BEQ with equal operands: taken, y = pc + imm.
- JAL at pc 0x100 with imm 0x20: pc_src_jal 1, y = 0x120, wb 10, reg_we 1.
  - LUI with imm 0x12345000: y = 0x12345000.
  - AUIPC at pc 0x10 with the same imm: y = 0x12345010.
- Counter and invalid opcode:
  - Hold rst = 0 for 2 cycles: o_insn_cnt = 0.
  - Release rst and run 3 valid instructions, then instr 0x00000000: count = 3. The invalid cycle shows insn_vld 0 and all write enables 0.
  - Assert rst again: count = 0 on the next edge.
